// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 serial receiver.
//   - rx_state_t   : receiver FSM state encoding
//   - SAMPLE_T*    : tick indices inside a bit at which the line is sampled
//   - calc_div     : clocks per 16x oversample tick
//   - majority3    : 2-of-3 vote used for every bit decision
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam logic [3:0] SAMPLE_T0 = 4'd7;
    localparam logic [3:0] SAMPLE_T1 = 4'd8;
    localparam logic [3:0] SAMPLE_T2 = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // Integer truncation: 50 MHz / (9600 * 16) gives 325.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / (baud * 32'd16);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: 16x oversample tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, re-phases the divider to a start edge
//   tick  : one-clock pulse every CLK_FREQ/(BAUD*16) clocks
module baud_tick_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    import uart_pkg::*;

    localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter 0..DIV-1; tick is registered when the count wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == DIV_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1'b1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial receiver with 16x oversampling and 2-of-3 voting.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   rs232_rx  : raw serial line, idle high, asynchronous to clk
//   po_data   : last correctly framed byte (LSB received first)
//   rx_down   : one-clock strobe, new byte on po_data
//   frame_err : one-clock strobe, stop bit voted low
//   rx_busy   : high from accepted start edge until the frame ends
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] po_data,
    output logic       rx_down,
    output logic       frame_err,
    output logic       rx_busy
);
    import uart_pkg::*;

    logic       sync1_r, sync2_r, prev_r;
    logic       fall_s, accept_s, tick_s, vote_s;
    rx_state_t  state_r;
    logic [3:0] tick_idx_r;
    logic [2:0] bit_idx_r;
    logic       samp0_r, samp1_r;
    logic [7:0] shift_r;
    logic [7:0] po_data_r;
    logic       rx_down_r, frame_err_r, rx_busy_r;

    // Two-flop synchroniser plus edge-history register, all idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rs232_rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Start-edge detection and the bit vote; the third sample is the live line.
    always_comb begin
        fall_s   = prev_r & ~sync2_r;
        accept_s = fall_s & (state_r == ST_IDLE);
        vote_s   = majority3(samp0_r, samp1_r, sync2_r);
    end

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_baud_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .tick  (tick_s)
    );

    // Capture the first two of the three mid-bit samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0_r <= 1'b0;
            samp1_r <= 1'b0;
        end else if (tick_s && (tick_idx_r == SAMPLE_T0)) begin
            samp0_r <= sync2_r;
        end else if (tick_s && (tick_idx_r == SAMPLE_T1)) begin
            samp1_r <= sync2_r;
        end else begin
            samp0_r <= samp0_r;
            samp1_r <= samp1_r;
        end
    end

    // Receiver FSM, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tick_idx_r  <= 4'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            po_data_r   <= 8'h00;
            rx_down_r   <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
        end else begin
            rx_down_r   <= 1'b0;
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tick_idx_r <= 4'd0;
                    bit_idx_r  <= 3'd0;
                    if (fall_s) begin
                        state_r   <= ST_START;
                        rx_busy_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        tick_idx_r <= tick_idx_r + 4'd1;
                        if ((tick_idx_r == SAMPLE_T2) && vote_s) begin
                            // Start bit did not hold low: treat as noise.
                            state_r   <= ST_IDLE;
                            rx_busy_r <= 1'b0;
                        end else if (tick_idx_r == LAST_TICK) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        tick_idx_r <= tick_idx_r + 4'd1;
                        if (tick_idx_r == SAMPLE_T2) begin
                            shift_r <= {vote_s, shift_r[7:1]};
                        end
                        if (tick_idx_r == LAST_TICK) begin
                            if (bit_idx_r == 3'd7) begin
                                state_r <= ST_STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        tick_idx_r <= tick_idx_r + 4'd1;
                        // Leave at mid stop bit so a slightly fast sender's
                        // next start edge is not missed.
                        if (tick_idx_r == SAMPLE_T2) begin
                            if (vote_s) begin
                                po_data_r <= shift_r;
                                rx_down_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                            state_r   <= ST_IDLE;
                            rx_busy_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rx_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign po_data   = po_data_r;
    assign rx_down   = rx_down_r;
    assign frame_err = frame_err_r;
    assign rx_busy   = rx_busy_r;

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// Bench for uart_byte_rx. Stimulus drives serial frames; a scoreboard queue
// holds the expected outcome of each frame and a monitor checks every strobe.
module tb_uart_byte_rx;
    // 12.8 MHz / (100 kbaud * 16) = 8 clocks per tick, 128 clocks per bit.
    localparam int unsigned CLK_FREQ = 12_800_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int NOM  = 128;
    localparam int FAST = 125;  // ~2.3% fast sender
    localparam int SLOW = 131;  // ~2.3% slow sender
    localparam int DIV  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] po_data;
    logic       rx_down, frame_err, rx_busy;

    int vectors = 0;
    int miscompares = 0;

    // bit 8 set: frame error expected; otherwise byte in [7:0]
    logic [8:0] exp_q[$];
    logic [7:0] exp_po = 8'h00;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .po_data   (po_data),
        .rx_down   (rx_down),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // Monitor: sample 1 ns after each rising edge and check against the queue.
    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (!rst_n) begin
            vectors++;
            if (po_data !== 8'h00 || rx_down !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_values: po_data=%h rx_down=%b frame_err=%b rx_busy=%b, required 00/0/0/0",
                         po_data, rx_down, frame_err, rx_busy);
            end
            exp_po = 8'h00;
        end else if (rx_down || frame_err) begin
            vectors++;
            if (rx_down && frame_err) begin
                miscompares++;
                $display("FAIL both_strobes: rx_down=1 frame_err=1, required at most one");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: rx_down=%b frame_err=%b po_data=%h, required no strobe",
                         rx_down, frame_err, po_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_down) begin
                    if (e[8]) begin
                        miscompares++;
                        $display("FAIL strobe_kind: got rx_down po_data=%h, required frame_err", po_data);
                    end else if (po_data !== e[7:0]) begin
                        miscompares++;
                        $display("FAIL rx_byte: po_data=%h, required %h", po_data, e[7:0]);
                    end
                end else if (!e[8]) begin
                    miscompares++;
                    $display("FAIL strobe_kind: got frame_err, required rx_down with %h", e[7:0]);
                end
                if (!e[8]) exp_po = e[7:0];
            end
        end else begin
            vectors++;
            if (po_data !== exp_po) begin
                miscompares++;
                $display("FAIL po_data_hold: po_data=%h, required %h", po_data, exp_po);
            end
        end
    end

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; optional 1-tick inverted glitch at tick 8 of data bit 3.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int bc, input bit glitch);
        int g0;
        int gw;
        g0 = (bc * 8) / 16;
        gw = bc / 16;
        rs232_rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            if (glitch && i == 3) begin
                repeat (g0) @(negedge clk);
                rs232_rx = ~d[i];
                repeat (gw) @(negedge clk);
                rs232_rx = d[i];
                repeat (bc - g0 - gw) @(negedge clk);
            end else begin
                repeat (bc) @(negedge clk);
            end
        end
        rs232_rx = stop_val;
        repeat (bc) @(negedge clk);
        rs232_rx = 1'b1;
    endtask

    // Model: a good stop bit yields the byte, a low stop bit a frame error.
    task automatic send_checked(input logic [7:0] d, input logic stop_val,
                                input int bc, input bit glitch);
        if (stop_val) exp_q.push_back({1'b0, d});
        else          exp_q.push_back({1'b1, 8'h00});
        send_frame(d, stop_val, bc, glitch);
    endtask

    task automatic check_drained(input string name);
        idle(2 * NOM);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [7:0] d;
        int bc;
        int gap;
        bit err;
        bit gl;

        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle(2 * NOM);

        // "X1" back to back at nominal rate
        send_checked(8'h58, 1'b1, NOM, 1'b0);
        send_checked(8'h31, 1'b1, NOM, 1'b0);
        check_drained("x1_pair");

        // False start: short low pulse well under half a bit
        busy_cnt = 0;
        rs232_rx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 23) rs232_rx = 1'b1;
            if (rx_busy) busy_cnt++;
        end
        vectors++;
        if (busy_cnt < 9 * DIV || busy_cnt > 11 * DIV + 2) begin
            miscompares++;
            $display("FAIL false_start_busy: busy for %0d clk, required %0d..%0d",
                     busy_cnt, 9 * DIV, 11 * DIV + 2);
        end
        check_bit("false_start_idle", rx_busy, 1'b0);
        check_drained("false_start");

        // Low stop bit, then a long break, then a clean frame
        send_checked(8'hA5, 1'b0, NOM, 1'b0);
        rs232_rx = 1'b0;
        repeat (4000) @(negedge clk);
        idle(2 * NOM);
        check_drained("break");
        send_checked(8'h3C, 1'b1, NOM, 1'b0);
        check_drained("after_break");

        // Glitch at tick 8 of bit 3 at nominal, fast and slow rates
        send_checked(8'h55, 1'b1, NOM, 1'b1);
        send_checked(8'h55, 1'b1, FAST, 1'b1);
        idle(NOM);
        send_checked(8'h55, 1'b1, SLOW, 1'b1);
        check_drained("glitch_tolerance");

        // Reset during data bit 4 of 0xFF; that frame must be discarded
        rs232_rx = 1'b0;
        repeat (NOM) @(negedge clk);
        rs232_rx = 1'b1;
        repeat (4 * NOM + NOM / 2) @(negedge clk);
        check_bit("busy_before_reset", rx_busy, 1'b1);
        rst_n = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        idle(6 * NOM);
        check_drained("reset_abort");
        send_checked(8'h0F, 1'b1, NOM, 1'b0);
        check_drained("after_reset");

        // Randomised frames: data, sender rate, gap, stop errors, glitches
        for (int n = 0; n < 20; n++) begin
            d   = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       bc = NOM;
                1:       bc = FAST;
                default: bc = SLOW;
            endcase
            err = ($urandom_range(0, 9) == 0);
            gl  = ($urandom_range(0, 3) == 0);
            gap = err ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
            send_checked(d, ~err, bc, gl);
            if (gap > 0) idle(gap * NOM);
        end
        check_drained("random_frames");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
